// File: rtl/stack_cmd_issuer.sv
// Upstream requester for the stack unit: takes commands on valid/ready, issues them over the
// toggle handshake, and returns the captured result (or a timeout result) on valid/ready.
module stack_cmd_issuer #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_W     = 10,
   parameter int unsigned OP_W    = 3,
   parameter int unsigned TMO_W   = 16,
   parameter int unsigned TMO_CYC = 1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [N_W-1:0]    cmd_n,
   output logic [OP_W-1:0]   op_out,
   output logic [DATA_W-1:0] datain_out,
   output logic [N_W-1:0]    n_out,
   output logic              rdy_out,
   input  logic              ack_in,
   input  logic [DATA_W-1:0] dataout_in,
   input  logic              esito_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_esito,
   output logic              res_timeout,
   output logic              err_timeout,
   output logic [7:0]        late_acks
);

   localparam int unsigned LATE_W = 8;
   localparam logic [LATE_W-1:0] LATE_MAX = '1;
   localparam bit TMO_EN = (TMO_CYC != 0);
   // Last count value before the timeout fires; unused when the timeout is disabled.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic             ack_seen;
   logic [TMO_W-1:0] tmo_cnt;
   logic             ack_ev;

   assign ack_ev    = (ack_in != ack_seen);
   assign cmd_ready = (state == IDLE) && !reset;

   // Request/response sequencer; ack_seen tracks the last absorbed ack level.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ack_seen    <= ack_in;
         tmo_cnt     <= '0;
         op_out      <= '0;
         datain_out  <= '0;
         n_out       <= '0;
         rdy_out     <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_esito   <= 1'b0;
         res_timeout <= 1'b0;
         err_timeout <= 1'b0;
         late_acks   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ack_ev) begin
                  ack_seen <= ack_in;
                  if (late_acks != LATE_MAX) late_acks <= late_acks + LATE_W'(1);
               end
               if (cmd_valid) begin
                  op_out     <= cmd_op;
                  datain_out <= cmd_data;
                  n_out      <= cmd_n;
                  rdy_out    <= ~rdy_out;
                  tmo_cnt    <= '0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (ack_ev) begin
                  ack_seen    <= ack_in;
                  res_data    <= dataout_in;
                  res_esito   <= esito_in;
                  res_timeout <= 1'b0;
                  res_valid   <= 1'b1;
                  state       <= HOLD;
               end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                  // ack_seen left alone so a straggling ack is counted as late.
                  res_data    <= '0;
                  res_esito   <= 1'b1;
                  res_timeout <= 1'b1;
                  err_timeout <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= HOLD;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            HOLD: begin
               if (ack_ev) begin
                  ack_seen <= ack_in;
                  if (late_acks != LATE_MAX) late_acks <= late_acks + LATE_W'(1);
               end
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cmd_issuer.sv
// Directed bench for stack_cmd_issuer with an 8-cycle timeout; the stack unit side is
// driven by hand inside each scenario task.
module tb_stack_cmd_issuer;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_data;
   logic [9:0]  cmd_n;
   logic [2:0]  op_out;
   logic [31:0] datain_out;
   logic [9:0]  n_out;
   logic        rdy_out;
   logic        ack_in;
   logic [31:0] dataout_in;
   logic        esito_in;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_esito;
   logic        res_timeout;
   logic        err_timeout;
   logic [7:0]  late_acks;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic exp_rdy = 1'b0;

   stack_cmd_issuer #(
      .DATA_W(32), .N_W(10), .OP_W(3), .TMO_W(16), .TMO_CYC(8)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_n(cmd_n),
      .op_out(op_out), .datain_out(datain_out), .n_out(n_out), .rdy_out(rdy_out),
      .ack_in(ack_in), .dataout_in(dataout_in), .esito_in(esito_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_esito(res_esito), .res_timeout(res_timeout),
      .err_timeout(err_timeout), .late_acks(late_acks)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [9:0] n);
      cmd_op = op; cmd_data = data; cmd_n = n; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      exp_rdy = ~exp_rdy;
   endtask

   task automatic test_reset();
      reset = 1'b1; ack_in = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_op = '0; cmd_data = '0; cmd_n = '0; dataout_in = '0; esito_in = 1'b0;
      tick(); tick();
      total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %0b want 0", cmd_ready); else pass_cnt++;
      total_cnt++; if (rdy_out !== 1'b0) $display("FAIL reset_rdy got %0b want 0", rdy_out); else pass_cnt++;
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", res_valid); else pass_cnt++;
      total_cnt++; if (datain_out !== 32'h0) $display("FAIL reset_datain got %h want 0", datain_out); else pass_cnt++;
      total_cnt++; if (err_timeout !== 1'b0 || late_acks !== 8'd0)
         $display("FAIL reset_err got err=%0b late=%0d want 0/0", err_timeout, late_acks); else pass_cnt++;
      reset = 1'b0;
      tick();
      total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", cmd_ready); else pass_cnt++;
      exp_rdy = 1'b0;
   endtask

   task automatic test_push();
      res_ready = 1'b0;
      issue(3'd1, 32'hDEADBEEF, 10'd0);
      total_cnt++; if (rdy_out !== exp_rdy) $display("FAIL push_rdy got %0b want %0b", rdy_out, exp_rdy); else pass_cnt++;
      total_cnt++; if (op_out !== 3'd1 || n_out !== 10'd0)
         $display("FAIL push_op got op=%0d n=%0d want 1/0", op_out, n_out); else pass_cnt++;
      total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL push_cmd_ready got %0b want 0", cmd_ready); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (datain_out !== 32'hDEADBEEF || res_valid !== 1'b0)
         $display("FAIL push_hold got datain=%h valid=%0b want deadbeef/0", datain_out, res_valid); else pass_cnt++;
      dataout_in = 32'h00001234; esito_in = 1'b0; ack_in = ~ack_in;
      tick();
      total_cnt++; if (res_valid !== 1'b1 || res_data !== 32'h00001234)
         $display("FAIL push_result got valid=%0b data=%h want 1/00001234", res_valid, res_data); else pass_cnt++;
      total_cnt++; if (res_esito !== 1'b0 || res_timeout !== 1'b0)
         $display("FAIL push_flags got esito=%0b tmo=%0b want 0/0", res_esito, res_timeout); else pass_cnt++;
      total_cnt++; if (rdy_out !== exp_rdy) $display("FAIL push_single_toggle got %0b want %0b", rdy_out, exp_rdy); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total_cnt++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL push_consume got valid=%0b ready=%0b want 0/1", res_valid, cmd_ready); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] want_lvl;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(3'(i), 32'h100 + 32'(i), 10'(i));
         want_lvl = 2'b10;
         total_cnt++; if (rdy_out !== want_lvl[i % 2]) $display("FAIL b2b_rdy_level[%0d] got %0b want %0b", i, rdy_out, want_lvl[i % 2]); else pass_cnt++;
         total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_cmd_ready_low[%0d] got %0b want 0", i, cmd_ready); else pass_cnt++;
         dataout_in = 32'hA000 + 32'(i); esito_in = 1'(i); ack_in = ~ack_in;
         tick();
         total_cnt++; if (res_valid !== 1'b1 || res_data !== 32'hA000 + 32'(i) || res_esito !== 1'(i))
            $display("FAIL b2b_result[%0d] got valid=%0b data=%h esito=%0b", i, res_valid, res_data, res_esito); else pass_cnt++;
         total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_hold[%0d] got %0b want 0", i, cmd_ready); else pass_cnt++;
         tick();
         total_cnt++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL b2b_consume[%0d] got valid=%0b ready=%0b want 0/1", i, res_valid, cmd_ready); else pass_cnt++;
      end
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      issue(3'd2, 32'h0, 10'd7);
      dataout_in = 32'h5555AAAA; esito_in = 1'b1; ack_in = ~ack_in;
      tick();
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         dataout_in = 32'hFFFF0000 + 32'(i); esito_in = 1'(i);
         tick();
         total_cnt++; if (res_valid !== 1'b1 || res_data !== 32'h5555AAAA || res_esito !== 1'b1)
            $display("FAIL bp_stable[%0d] got valid=%0b data=%h esito=%0b", i, res_valid, res_data, res_esito); else pass_cnt++;
         total_cnt++; if (cmd_ready !== 1'b0 || rdy_out !== exp_rdy)
            $display("FAIL bp_no_issue[%0d] got ready=%0b rdy=%0b want 0/%0b", i, cmd_ready, rdy_out, exp_rdy); else pass_cnt++;
      end
      cmd_valid = 1'b0; res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL bp_release got %0b want 0", res_valid); else pass_cnt++;
   endtask

   task automatic test_ack_at_timeout();
      res_ready = 1'b0;
      issue(3'd3, 32'h0, 10'd1);
      for (int i = 0; i < 7; i++) tick();
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL race_early got %0b want 0", res_valid); else pass_cnt++;
      dataout_in = 32'h0BADF00D; esito_in = 1'b0; ack_in = ~ack_in;
      tick();
      total_cnt++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_data !== 32'h0BADF00D)
         $display("FAIL race_result got valid=%0b tmo=%0b data=%h", res_valid, res_timeout, res_data); else pass_cnt++;
      total_cnt++; if (err_timeout !== 1'b0 || res_esito !== 1'b0)
         $display("FAIL race_err got err=%0b esito=%0b want 0/0", err_timeout, res_esito); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total_cnt++; if (late_acks !== 8'd0) $display("FAIL race_late got %0d want 0", late_acks); else pass_cnt++;
   endtask

   task automatic test_timeout();
      res_ready = 1'b0;
      dataout_in = 32'h77777777; esito_in = 1'b0;
      issue(3'd4, 32'h0, 10'd2);
      for (int i = 0; i < 7; i++) tick();
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL tmo_early got %0b want 0", res_valid); else pass_cnt++;
      tick();
      total_cnt++; if (res_valid !== 1'b1 || res_timeout !== 1'b1)
         $display("FAIL tmo_fire got valid=%0b tmo=%0b want 1/1", res_valid, res_timeout); else pass_cnt++;
      total_cnt++; if (res_esito !== 1'b1 || res_data !== 32'h0 || err_timeout !== 1'b1)
         $display("FAIL tmo_payload got esito=%0b data=%h err=%0b want 1/0/1", res_esito, res_data, err_timeout); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      ack_in = ~ack_in;
      tick();
      total_cnt++; if (late_acks !== 8'd1) $display("FAIL tmo_late_ack got %0d want 1", late_acks); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || err_timeout !== 1'b1)
         $display("FAIL tmo_no_extra got valid=%0b ready=%0b err=%0b want 0/1/1", res_valid, cmd_ready, err_timeout); else pass_cnt++;
   endtask

   task automatic test_reset_mid_wait();
      res_ready = 1'b0;
      issue(3'd5, 32'hCAFEF00D, 10'd3);
      reset = 1'b1; ack_in = 1'b1;
      tick(); tick();
      total_cnt++; if (rdy_out !== 1'b0 || res_valid !== 1'b0 || op_out !== 3'd0)
         $display("FAIL rst_wait_outs got rdy=%0b valid=%0b op=%0d want 0/0/0", rdy_out, res_valid, op_out); else pass_cnt++;
      reset = 1'b0;
      tick();
      total_cnt++; if (cmd_ready !== 1'b1 || late_acks !== 8'd0 || err_timeout !== 1'b0)
         $display("FAIL rst_wait_release got ready=%0b late=%0d err=%0b want 1/0/0", cmd_ready, late_acks, err_timeout); else pass_cnt++;
      tick(); tick(); tick();
      total_cnt++; if (res_valid !== 1'b0 || late_acks !== 8'd0 || rdy_out !== 1'b0)
         $display("FAIL rst_wait_spurious got valid=%0b late=%0d rdy=%0b want 0/0/0", res_valid, late_acks, rdy_out); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_push();
      test_back_to_back();
      test_backpressure();
      test_ack_at_timeout();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
